jit_demux: RTL and testbench

JIT_DEMUX -- requirements
Module: jit_demux

---
 rtl/jit_demux.sv | 150 +++++++++++++++
 tb/tb_jit_demux.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jit_demux.sv
// jit_demux: routes one length-bounded burst from the accelerator result stream to one of three AXI-Stream masters.
// Latency: a word accepted in cycle t is presented on the selected master in cycle t+1; 1 word/cycle sustained.
// Backpressure: the 2-entry buffer absorbs destination stalls; sIn_tready drops only when full with no pop this cycle.
//
// Ports:
//   ACLK, ARESET              clock, synchronous active-high reset
//   START, CONF, LEN          burst request; CONF selects mOut1..3 (0 = none), LEN = word count
//   sIn_*                     slave stream from the accelerator
//   mOut1_*, mOut2_*, mOut3_* master destination streams (only the selected one is ever active)
//   BUSY, DONE, SENT          status: not idle, completion pulse, words delivered in current/last burst
module jit_demux #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              START,
  input  logic [1:0]        CONF,
  input  logic [LEN_W-1:0]  LEN,
  output logic              sIn_tready,
  input  logic              sIn_tvalid,
  input  logic [DATA_W-1:0] sIn_tdata,
  input  logic              mOut1_tready,
  output logic              mOut1_tvalid,
  output logic [DATA_W-1:0] mOut1_tdata,
  input  logic              mOut2_tready,
  output logic              mOut2_tvalid,
  output logic [DATA_W-1:0] mOut2_tdata,
  input  logic              mOut3_tready,
  output logic              mOut3_tvalid,
  output logic [DATA_W-1:0] mOut3_tdata,
  output logic              BUSY,
  output logic              DONE,
  output logic [LEN_W-1:0]  SENT
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [1:0]         conf_q;
  // The remaining counter is the burst's latched length: loaded from LEN, counted down per accept.
  logic [LEN_W-1:0]   rem_q;
  logic [LEN_W-1:0]   sent_q;
  logic               done_q;

  // Two-entry buffer: one-bit pointers, count in 0..2.
  logic [DATA_W-1:0]  mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;

  logic               sel_ready;
  logic               fifo_nonempty;
  logic               pop;
  logic               push;
  logic               in_ready;
  logic [DATA_W-1:0]  head;

  // Only the selected destination's tready is looked at; the others are don't-care.
  always_comb begin
    sel_ready = 1'b0;
    case (conf_q)
      2'd1:    sel_ready = mOut1_tready;
      2'd2:    sel_ready = mOut2_tready;
      2'd3:    sel_ready = mOut3_tready;
      default: sel_ready = 1'b0;
    endcase
  end

  assign fifo_nonempty = (count != 2'd0);
  assign head          = mem[rd_ptr];
  assign pop           = fifo_nonempty && sel_ready;
  // Full buffer still accepts when the head leaves in the same cycle, keeping 1 word/cycle.
  assign in_ready      = (state == RUN) && ((count != 2'd2) || pop);
  assign push          = sIn_tvalid && in_ready;

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr] <= sIn_tdata;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= IDLE;
      conf_q <= 2'd0;
      rem_q  <= '0;
      sent_q <= '0;
      done_q <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      done_q <= 1'b0;

      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (pop) sent_q <= sent_q + LEN_W'(1);

      case (state)
        IDLE: begin
          if (START) begin
            if ((CONF != 2'd0) && (LEN != '0)) begin
              conf_q <= CONF;
              rem_q  <= LEN;
              sent_q <= '0;
              state  <= RUN;
            end else begin
              // Degenerate request: acknowledge immediately, nothing to move.
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push) begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The edge that empties the buffer ends the burst; DONE is high in the following cycle.
          if (!fifo_nonempty || (pop && (count == 2'd1))) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held so nothing leaks before the first reset edge.
  assign sIn_tready   = in_ready && !ARESET;
  assign mOut1_tvalid = !ARESET && (conf_q == 2'd1) && fifo_nonempty;
  assign mOut2_tvalid = !ARESET && (conf_q == 2'd2) && fifo_nonempty;
  assign mOut3_tvalid = !ARESET && (conf_q == 2'd3) && fifo_nonempty;
  assign mOut1_tdata  = mOut1_tvalid ? head : '0;
  assign mOut2_tdata  = mOut2_tvalid ? head : '0;
  assign mOut3_tdata  = mOut3_tvalid ? head : '0;
  assign BUSY         = !ARESET && (state != IDLE);
  assign DONE         = !ARESET && done_q;
  assign SENT         = sent_q;

endmodule

// File: tb/tb_jit_demux.sv
// tb_jit_demux: directed cycle-by-cycle vectors for jit_demux plus a long randomised burst with a scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after the rising edge.
// Clock period 10.
module tb_jit_demux;

  logic        ACLK;
  logic        ARESET;
  logic        START;
  logic [1:0]  CONF;
  logic [15:0] LEN;
  logic        sIn_tready, sIn_tvalid;
  logic [31:0] sIn_tdata;
  logic        mOut1_tready, mOut1_tvalid;
  logic [31:0] mOut1_tdata;
  logic        mOut2_tready, mOut2_tvalid;
  logic [31:0] mOut2_tdata;
  logic        mOut3_tready, mOut3_tvalid;
  logic [31:0] mOut3_tdata;
  logic        BUSY, DONE;
  logic [15:0] SENT;

  int errors = 0;
  int checks = 0;

  jit_demux #(.DATA_W(32), .LEN_W(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .START(START), .CONF(CONF), .LEN(LEN),
    .sIn_tready(sIn_tready), .sIn_tvalid(sIn_tvalid), .sIn_tdata(sIn_tdata),
    .mOut1_tready(mOut1_tready), .mOut1_tvalid(mOut1_tvalid), .mOut1_tdata(mOut1_tdata),
    .mOut2_tready(mOut2_tready), .mOut2_tvalid(mOut2_tvalid), .mOut2_tdata(mOut2_tdata),
    .mOut3_tready(mOut3_tready), .mOut3_tvalid(mOut3_tvalid), .mOut3_tdata(mOut3_tdata),
    .BUSY(BUSY), .DONE(DONE), .SENT(SENT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  // Checks the three master lanes: sel is the lane expected to carry data (0 = none),
  // v whether it should be valid, d the expected word when valid. Other lanes must be all-zero.
  task automatic lanes(input string tag, input int sel, input bit v, input logic [31:0] d);
    logic [2:0]  vexp;
    logic [31:0] dsel;
    logic [31:0] zor;
    vexp = 3'b000;
    if (v && sel == 1) vexp = 3'b001;
    if (v && sel == 2) vexp = 3'b010;
    if (v && sel == 3) vexp = 3'b100;
    chk({tag, "_vld"}, {61'd0, mOut3_tvalid, mOut2_tvalid, mOut1_tvalid}, {61'd0, vexp});
    case (sel)
      1:       begin dsel = mOut1_tdata; zor = mOut2_tdata | mOut3_tdata; end
      2:       begin dsel = mOut2_tdata; zor = mOut1_tdata | mOut3_tdata; end
      3:       begin dsel = mOut3_tdata; zor = mOut1_tdata | mOut2_tdata; end
      default: begin dsel = 32'd0; zor = mOut1_tdata | mOut2_tdata | mOut3_tdata; end
    endcase
    if (v) chk({tag, "_dat"}, {32'd0, dsel}, {32'd0, d});
    chk({tag, "_zero"}, {32'd0, zor}, 64'd0);
  endtask

  function automatic logic [31:0] word_of(input int i);
    logic [31:0] x;
    x = 32'(i) * 32'h9E3779B1;
    return x ^ 32'h5A5A0000;
  endfunction

  int  in_idx, out_idx, bad, dones, ncyc;
  bit  pend;

  initial begin
    ARESET = 1'b1; START = 1'b0; CONF = 2'd0; LEN = 16'd0;
    sIn_tvalid = 1'b0; sIn_tdata = 32'd0;
    mOut1_tready = 1'b0; mOut2_tready = 1'b0; mOut3_tready = 1'b0;

    // ---- reset: outputs low even with busy-looking inputs ----
    step; step;
    sIn_tvalid = 1'b1; sIn_tdata = 32'hFFFF_FFFF; START = 1'b1; CONF = 2'd2; LEN = 16'd4;
    mOut1_tready = 1'b1; mOut2_tready = 1'b1; mOut3_tready = 1'b1;
    settle;
    chk("rst_tready", sIn_tready, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_sent", SENT, 0);
    lanes("rst", 0, 0, 0);

    // ---- burst CONF=2 LEN=4, back-to-back, START on first cycle out of reset ----
    step; ARESET = 1'b0; sIn_tvalid = 1'b0; START = 1'b1; CONF = 2'd2; LEN = 16'd4;
    settle;
    chk("b1_idle_busy", BUSY, 0);
    chk("b1_idle_tready", sIn_tready, 0);
    step; START = 1'b0; sIn_tvalid = 1'b1; sIn_tdata = 32'hA0;
    settle;
    chk("b1_run_busy", BUSY, 1);
    chk("b1_run_tready", sIn_tready, 1);
    lanes("b1_c0", 2, 0, 0);
    for (int i = 1; i < 4; i++) begin
      step; sIn_tdata = 32'hA0 + 32'(i);
      settle;
      chk("b1_tready", sIn_tready, 1);
      lanes("b1_w", 2, 1, 32'hA0 + 32'(i - 1));
    end
    step; sIn_tvalid = 1'b0;
    settle;
    chk("b1_drain_tready", sIn_tready, 0);
    chk("b1_drain_sent", SENT, 3);
    chk("b1_drain_done", DONE, 0);
    lanes("b1_w3", 2, 1, 32'hA3);
    step; settle;
    chk("b1_done", DONE, 1);
    chk("b1_sent", SENT, 4);
    chk("b1_busy_end", BUSY, 0);
    lanes("b1_end", 0, 0, 0);
    step; settle;
    chk("b1_done_once", DONE, 0);

    // ---- CONF=3 LEN=3 with destination stalled 5 cycles ----
    mOut3_tready = 1'b0; START = 1'b1; CONF = 2'd3; LEN = 16'd3;
    step; START = 1'b0; sIn_tvalid = 1'b1; sIn_tdata = 32'hB0;
    settle;
    chk("b2_r1_tready", sIn_tready, 1);
    lanes("b2_r1", 3, 0, 0);
    step; sIn_tdata = 32'hB1;
    settle;
    chk("b2_r2_tready", sIn_tready, 1);
    lanes("b2_r2", 3, 1, 32'hB0);
    step; sIn_tdata = 32'hB2;
    for (int k = 0; k < 3; k++) begin
      settle;
      chk("b2_full_tready", sIn_tready, 0);
      lanes("b2_hold", 3, 1, 32'hB0);
      step;
    end
    mOut3_tready = 1'b1;
    settle;
    chk("b2_pushpop_tready", sIn_tready, 1);
    lanes("b2_r6", 3, 1, 32'hB0);
    step; sIn_tvalid = 1'b0;
    settle;
    chk("b2_drain_tready", sIn_tready, 0);
    chk("b2_sent1", SENT, 1);
    lanes("b2_r7", 3, 1, 32'hB1);
    step; settle;
    lanes("b2_r8", 3, 1, 32'hB2);
    step; settle;
    chk("b2_done", DONE, 1);
    chk("b2_sent", SENT, 3);

    // ---- degenerate starts: LEN=0, then CONF=0 ----
    step; START = 1'b1; CONF = 2'd1; LEN = 16'd0;
    settle;
    chk("z1_pre_done", DONE, 0);
    step; START = 1'b1; CONF = 2'd0; LEN = 16'd5;
    settle;
    chk("z1_done", DONE, 1);
    chk("z1_busy", BUSY, 0);
    lanes("z1", 0, 0, 0);
    step; START = 1'b0;
    settle;
    chk("z2_done", DONE, 1);
    chk("z2_busy", BUSY, 0);
    chk("z2_tready", sIn_tready, 0);
    lanes("z2", 0, 0, 0);
    step; settle;
    chk("z2_done_once", DONE, 0);
    chk("z2_busy_after", BUSY, 0);

    // ---- second START during RUN is ignored ----
    mOut1_tready = 1'b1; mOut2_tready = 1'b1; START = 1'b1; CONF = 2'd2; LEN = 16'd3;
    step; START = 1'b1; CONF = 2'd1; LEN = 16'd7; sIn_tvalid = 1'b1; sIn_tdata = 32'hC0;
    settle;
    chk("b3_tready", sIn_tready, 1);
    step; START = 1'b0; sIn_tdata = 32'hC1;
    settle;
    lanes("b3_w0", 2, 1, 32'hC0);
    step; sIn_tdata = 32'hC2;
    settle;
    lanes("b3_w1", 2, 1, 32'hC1);
    step; sIn_tvalid = 1'b0;
    settle;
    lanes("b3_w2", 2, 1, 32'hC2);
    step; settle;
    chk("b3_done", DONE, 1);
    chk("b3_sent", SENT, 3);

    // ---- reset mid-burst, then a fresh CONF=1 LEN=2 burst ----
    step; mOut2_tready = 1'b0; START = 1'b1; CONF = 2'd2; LEN = 16'd5;
    step; START = 1'b0; sIn_tvalid = 1'b1; sIn_tdata = 32'hD0;
    step; sIn_tdata = 32'hD1;
    step; ARESET = 1'b1; sIn_tdata = 32'hD2; mOut2_tready = 1'b1;
    settle;
    chk("ab_rst_tready", sIn_tready, 0);
    chk("ab_rst_busy", BUSY, 0);
    chk("ab_rst_done", DONE, 0);
    lanes("ab_rst", 0, 0, 0);
    step; ARESET = 1'b0; sIn_tvalid = 1'b0; START = 1'b1; CONF = 2'd1; LEN = 16'd2;
    settle;
    chk("ab_post_busy", BUSY, 0);
    chk("ab_post_done", DONE, 0);
    chk("ab_post_sent", SENT, 0);
    lanes("ab_post", 0, 0, 0);
    step; START = 1'b0; sIn_tvalid = 1'b1; sIn_tdata = 32'hE0;
    settle;
    chk("b4_tready", sIn_tready, 1);
    chk("b4_nodone", DONE, 0);
    lanes("b4_c0", 1, 0, 0);
    step; sIn_tdata = 32'hE1;
    settle;
    lanes("b4_w0", 1, 1, 32'hE0);
    step; sIn_tvalid = 1'b0;
    settle;
    chk("b4_drain_tready", sIn_tready, 0);
    lanes("b4_w1", 1, 1, 32'hE1);
    step; settle;
    chk("b4_done", DONE, 1);
    chk("b4_sent", SENT, 2);
    step; settle;
    chk("b4_done_once", DONE, 0);

    // ---- long random burst CONF=3 LEN=65535 with scoreboard ----
    START = 1'b1; CONF = 2'd3; LEN = 16'hFFFF;
    step; START = 1'b0;
    in_idx = 0; out_idx = 0; bad = 0; dones = 0; ncyc = 0; pend = 1'b0;
    while (dones == 0 && ncyc < 90000) begin
      if (!pend) begin
        sIn_tvalid = ($urandom_range(31) != 0);
        sIn_tdata  = word_of(in_idx);
      end
      mOut3_tready = ($urandom_range(31) != 0);
      mOut1_tready = 1'($urandom_range(1));
      mOut2_tready = 1'($urandom_range(1));
      settle;
      if (mOut1_tvalid || mOut2_tvalid) bad++;
      if (mOut3_tvalid && mOut3_tready) begin
        if (mOut3_tdata !== word_of(out_idx)) bad++;
        out_idx++;
      end
      if (DONE) dones++;
      pend = sIn_tvalid && !sIn_tready;
      if (sIn_tvalid && sIn_tready) in_idx++;
      step;
      ncyc++;
    end
    chk("rand_timeout", {63'd0, (dones == 0)}, 64'd0);
    chk("rand_sent", SENT, 16'hFFFF);
    sIn_tvalid = 1'b0;
    repeat (4) begin
      settle;
      if (DONE) dones++;
      step;
    end
    chk("rand_dones", dones, 1);
    chk("rand_in", in_idx, 65535);
    chk("rand_out", out_idx, 65535);
    chk("rand_bad", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
